sb_io_pad_arbiter: RTL and testbench

// - Shares one bidirectional package pin between N_REQ requesters using round-robin arbitration.
// - Drives the control/data inputs of one registered SB_IO: PIN_TYPE 6'b1101_00, i.e.

---
 rtl/sb_io_arb_pkg.sv | 21 ++
 rtl/sb_io_pad_arbiter_if.sv | 16 +
 rtl/sb_io_pad_arbiter_rd_pipe.sv | 32 +++
 rtl/sb_io_pad_arbiter.sv | 156 +++++++++++++++
 tb/tb_sb_io_pad_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sb_io_arb_pkg.sv
// Shared types and constants for the SB_IO pad arbiter.
package sb_io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Registered output, registered OE, registered input.
    localparam logic [5:0] SB_IO_PIN_TYPE_REG_BIDIR = 6'b1101_00;

    // Ceiling log2, never below 1 so single-value counters still get a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/sb_io_pad_arbiter_if.sv
// Requester-side bus of the SB_IO pad arbiter: per-requester control in, grant and read return out.
interface sb_io_pad_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic [N_REQ-1:0] drive;
    logic [N_REQ-1:0] dout;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             din;
    logic [N_REQ-1:0] din_valid;

    modport master (output req, last, drive, dout, input gnt, busy, din, din_valid);
    modport slave  (input req, last, drive, dout, output gnt, busy, din, din_valid);
endinterface

// File: rtl/sb_io_pad_arbiter_rd_pipe.sv
// Fixed-latency shift register with synchronous clear; carries the one-hot read tags
// so each returned pad sample is routed to the requester that asked for it.
module sb_io_rd_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int k = 1; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/sb_io_pad_arbiter.sv
// Round-robin ownership of one registered SB_IO pad, with released-pad turnaround
// gaps and a tagged read-return path aligned to the pad register latency.
module sb_io_pad_arbiter
    import sb_io_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    sb_io_pad_arbiter_if.slave bus,
    output logic               io_d_out_0,
    output logic               io_output_enable,
    output logic               io_clock_enable,
    input  logic               io_d_in_0
);
    localparam int unsigned IDX_W  = clog2(N_REQ);
    localparam int unsigned HOLD_W = clog2(MAX_HOLD);
    localparam int unsigned TURN_W = clog2(TURNAROUND);

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 1 || TURNAROUND < 1 ||
        (SB_IO_PIN_TYPE_REG_BIDIR[1:0] == 2'b00 && RD_LAT < 2)) begin : g_param_check
        $error("sb_io_pad_arbiter: unsupported parameter set");
    end

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              ce_q, ce_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [N_REQ-1:0]  pick_oh;
    logic              granted;
    logic              own_req, own_last, own_drive, own_dout;
    logic              release_c;
    logic [N_REQ-1:0]  rd_tag;
    logic [N_REQ-1:0]  rd_tag_out;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IDX_W'((32'(rr_q) + 32'(k)) % N_REQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_oh   = N_REQ'(1) << pick_idx;
    assign granted   = (state_q == GRANT);
    assign own_req   = bus.req[owner_q];
    assign own_last  = bus.last[owner_q];
    assign own_drive = bus.drive[owner_q];
    assign own_dout  = bus.dout[owner_q];
    assign release_c = own_last | ~own_req | (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        ce_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                if (release_c) begin
                    gnt_d   = '0;
                    rr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    turn_d  = '0;
                    state_d = TURN;
                end
            end
            TURN: begin
                // Only the last turnaround cycle may hand the pad to the next owner.
                if (turn_q == TURN_W'(TURNAROUND - 1)) begin
                    if (pick_found) begin
                        gnt_d   = pick_oh;
                        owner_d = pick_idx;
                        hold_d  = '0;
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            ce_q    <= ce_d;
        end
    end

    // Gated by rst so the SB_IO OE register captures 0 on the reset edge.
    assign io_output_enable = granted & ~rst & own_req & own_drive;
    assign io_d_out_0       = granted & ~rst & own_dout;
    assign io_clock_enable  = ce_q;

    assign rd_tag = (granted & ~rst & own_req & ~own_drive) ? gnt_q : '0;

    sb_io_rd_pipe #(
        .WIDTH (N_REQ),
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk (clk),
        .clr (rst),
        .d   (rd_tag),
        .q   (rd_tag_out)
    );

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.din_valid = rd_tag_out;
    assign bus.din       = (|rd_tag_out) & io_d_in_0;
endmodule

// File: tb/tb_sb_io_pad_arbiter.sv
// Directed bench for sb_io_pad_arbiter: behavioural registered SB_IO (PIN_TYPE 1101_00)
// feeding a pulled-up pad that the bench can also drive for read tests.
module tb_sb_io_pad_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sb_io_pad_arbiter_if #(.N_REQ(N)) bus ();

    logic io_d_out_0, io_oe, io_ce, io_d_in_0;
    logic sb_dout_q = 1'b0;
    logic sb_oe_q   = 1'b0;
    logic sb_din_q  = 1'b0;
    logic pad_en    = 1'b0;
    logic pad_val   = 1'b0;
    logic pad;
    logic [3:0] oh;
    int checks = 0;
    int errors = 0;

    sb_io_pad_arbiter #(
        .N_REQ      (N),
        .MAX_HOLD   (16),
        .TURNAROUND (1),
        .RD_LAT     (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .io_d_out_0       (io_d_out_0),
        .io_output_enable (io_oe),
        .io_clock_enable  (io_ce),
        .io_d_in_0        (io_d_in_0)
    );

    // SB_IO output, OE and input registers, all qualified by CLOCK_ENABLE.
    always @(posedge clk) begin
        if (io_ce === 1'b1) begin
            sb_dout_q <= io_d_out_0;
            sb_oe_q   <= io_oe;
            sb_din_q  <= pad;
        end
    end

    assign pad       = sb_oe_q ? sb_dout_q : (pad_en ? pad_val : 1'b1);
    assign io_d_in_0 = sb_din_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drv(input logic [3:0] r, input logic [3:0] l, input logic [3:0] d, input logic [3:0] o);
        bus.req   = r;
        bus.last  = l;
        bus.drive = d;
        bus.dout  = o;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        drv(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset state
        step(); #1;
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_dv", bus.din_valid, 0);
        check("rst_din", bus.din, 0);
        check("rst_oe", io_oe, 0);
        check("rst_dout", io_d_out_0, 0);
        check("rst_ce", io_ce, 0);
        step(); rst = 1'b0;
        step(); #1;
        check("ce_after_rst", io_ce, 1);
        check("idle_busy", bus.busy, 0);

        // Single owner 0 driving 1,0,1,0 with last on the 4th cycle
        step(); drv(4'b0001, 4'b0000, 4'b0001, 4'b0001); #1;
        check("t1_gnt_lat", bus.gnt, 0);
        step(); #1;
        check("t1_g1_gnt", bus.gnt, 4'b0001);
        check("t1_g1_oe", io_oe, 1);
        check("t1_g1_dout", io_d_out_0, 1);
        step(); bus.dout = 4'b0000; #1;
        check("t1_pad0", pad, 1);
        check("t1_g2_dout", io_d_out_0, 0);
        step(); bus.dout = 4'b0001; #1;
        check("t1_pad1", pad, 0);
        step(); bus.dout = 4'b0000; bus.last = 4'b0001; #1;
        check("t1_pad2", pad, 1);
        check("t1_g4_gnt", bus.gnt, 4'b0001);
        step(); drv(4'b0000, 4'b0000, 4'b0000, 4'b0000); #1;
        check("t1_turn_gnt", bus.gnt, 0);
        check("t1_turn_busy", bus.busy, 1);
        check("t1_turn_oe", io_oe, 0);
        check("t1_pad3", pad, 0);
        step(); #1;
        check("t1_idle_busy", bus.busy, 0);
        check("t1_pad_released", pad, 1);

        // All four requesting: rotation 0,1,2,3,0 from a fresh pointer
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step(); drv(4'b1111, 4'b0000, 4'b1111, 4'b1111); #1;
        for (int t = 0; t < 5; t++) begin
            oh = 4'b0001 << (t % 4);
            step(); bus.last = ~oh; #1;
            check("t2_g1_gnt", bus.gnt, oh);
            check("t2_g1_oe", io_oe, 1);
            step(); bus.last = oh; if (t == 4) bus.req = oh; #1;
            check("t2_g2_gnt", bus.gnt, oh);
            step(); bus.last = 4'b0000; if (t == 4) bus.req = 4'b0000; #1;
            check("t2_turn_gnt", bus.gnt, 0);
            check("t2_turn_oe", io_oe, 0);
        end
        step(); #1;
        check("t2_idle", bus.busy, 0);

        // Owner 2 never finishes: forced release after 16 cycles, pending 3 goes next
        step(); drv(4'b0100, 4'b0000, 4'b0100, 4'b0000); #1;
        for (int h = 0; h < 16; h++) begin
            step(); if (h == 0) bus.req = 4'b1100; #1;
            check("t3_hold_gnt", bus.gnt, 4'b0100);
        end
        step(); bus.last = 4'b1000; #1;
        check("t3_forced_rel", bus.gnt, 0);
        step(); #1;
        check("t3_next_gnt3", bus.gnt, 4'b1000);
        step(); bus.last = 4'b0000; bus.req = 4'b0100; #1;
        check("t3_one_cycle", bus.gnt, 0);
        step(); bus.req = 4'b0000; #1;
        check("t3_regrant2", bus.gnt, 4'b0100);
        check("t3_drop_oe", io_oe, 0);
        step(); #1;
        check("t3_drop_turn", bus.gnt, 0);
        step(); #1;
        check("t3_idle", bus.busy, 0);

        // Owner 1 samples the pad for 3 cycles while the bench drives 1,1,0
        step(); drv(4'b0010, 4'b0000, 4'b0000, 4'b0000); #1;
        step(); #1;
        check("t4_g1_gnt", bus.gnt, 4'b0010);
        check("t4_g1_oe", io_oe, 0);
        step(); pad_en = 1'b1; pad_val = 1'b1; #1;
        check("t4_dv_early", bus.din_valid, 0);
        step(); pad_val = 1'b1; bus.last = 4'b0010; bus.req = 4'b0011;
        bus.drive = 4'b0001; bus.dout = 4'b0001; #1;
        check("t4_dv0", bus.din_valid, 4'b0010);
        check("t4_din0", bus.din, 1);
        check("t4_nonowner_oe", io_oe, 0);
        check("t4_nonowner_dout", io_d_out_0, 0);
        step(); pad_val = 1'b0; bus.last = 4'b0001; #1;
        check("t4_dv1", bus.din_valid, 4'b0010);
        check("t4_din1", bus.din, 1);
        check("t4_turn_gnt", bus.gnt, 0);
        step(); pad_en = 1'b0; #1;
        check("t4_gnt0", bus.gnt, 4'b0001);
        check("t4_dv2", bus.din_valid, 4'b0010);
        check("t4_din2", bus.din, 0);
        check("t4_oe0", io_oe, 1);
        step(); drv(4'b0000, 4'b0000, 4'b0000, 4'b0000); #1;
        check("t4_dv_done", bus.din_valid, 0);
        check("t4_din_gated", bus.din, 0);
        step(); #1;
        check("t4_idle", bus.busy, 0);

        // Reset on the 3rd grant cycle with a read in flight
        step(); drv(4'b0100, 4'b0000, 4'b0100, 4'b0100); #1;
        step(); #1;
        check("t5_g1_gnt", bus.gnt, 4'b0100);
        check("t5_g1_oe", io_oe, 1);
        step(); bus.drive = 4'b0000; #1;
        check("t5_g2_oe", io_oe, 0);
        step(); rst = 1'b1; bus.drive = 4'b0100; #1;
        check("t5_rst_oe", io_oe, 0);
        check("t5_rst_dv", bus.din_valid, 0);
        step(); rst = 1'b0; drv(4'b0000, 4'b0000, 4'b0000, 4'b0000); #1;
        check("t5_after_gnt", bus.gnt, 0);
        check("t5_after_busy", bus.busy, 0);
        check("t5_after_dv", bus.din_valid, 0);
        check("t5_pad_oe", sb_oe_q, 0);
        check("t5_after_ce", io_ce, 0);
        step(); bus.req = 4'b1111; #1;
        check("t5_dv_flushed", bus.din_valid, 0);
        check("t5_ce_back", io_ce, 1);
        step(); bus.last = 4'b1111; #1;
        check("t5_rr_restart", bus.gnt, 4'b0001);
        step(); drv(4'b0000, 4'b0000, 4'b0000, 4'b0000); #1;
        check("t5_turn_gnt", bus.gnt, 0);
        step(); #1;
        check("t5_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
